// File: rtl/cache_pkg.sv
// Shared widths, controller state encoding and line byte helpers for the
// cache controller slice.
package cache_pkg;

    localparam int TAG_W   = 3;
    localparam int SET_W   = 3;
    localparam int DATA_W  = 8;
    localparam int BLOCK_W = 16;
    localparam int WAYS    = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        RD,
        WAIT,
        FILL,
        RESP
    } state_t;

    // Byte 1 occupies the upper half of the line, byte 0 the lower half.
    function automatic logic [BLOCK_W-1:0] merge_byte(
        input logic [BLOCK_W-1:0] blk,
        input logic               off,
        input logic [DATA_W-1:0]  data,
        input logic               en
    );
        logic [BLOCK_W-1:0] r;
        r = blk;
        if (en) begin
            if (off) begin
                r[BLOCK_W-1:DATA_W] = data;
            end else begin
                r[DATA_W-1:0] = data;
            end
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] pick_byte(
        input logic [BLOCK_W-1:0] blk,
        input logic               off
    );
        return off ? blk[BLOCK_W-1:DATA_W] : blk[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/cache_perf_cnt.sv
// Saturating hit / miss / writeback event counters for the cache controller.
module cache_perf_cnt (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inc_hit,
    input  logic        i_inc_miss,
    input  logic        i_inc_wb,
    output logic [15:0] o_hits,
    output logic [15:0] o_misses,
    output logic [15:0] o_wbacks
);

    logic [15:0] r_hits;
    logic [15:0] r_misses;
    logic [15:0] r_wbacks;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hits   <= '0;
            r_misses <= '0;
            r_wbacks <= '0;
        end else begin
            if (i_inc_hit && (r_hits != '1)) begin
                r_hits <= r_hits + 16'd1;
            end
            if (i_inc_miss && (r_misses != '1)) begin
                r_misses <= r_misses + 16'd1;
            end
            if (i_inc_wb && (r_wbacks != '1)) begin
                r_wbacks <= r_wbacks + 16'd1;
            end
        end
    end

    assign o_hits   = r_hits;
    assign o_misses = r_misses;
    assign o_wbacks = r_wbacks;

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Write-back / write-allocate sequencer between CPU port, 2-way tag/data array
// and memory. Define CACHE_CTRL_PERF_EN to add saturating perf counter outputs.
module cache_ctrl_fsm
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
`ifdef CACHE_CTRL_PERF_EN
    output logic [15:0]        perf_hits,
    output logic [15:0]        perf_misses,
    output logic [15:0]        perf_wbacks,
`endif
    input  logic               cpu_req_valid,
    output logic               cpu_req_ready,
    input  logic               cpu_req_we,
    input  logic [TAG_W-1:0]   cpu_req_tag,
    input  logic [SET_W-1:0]   cpu_req_set,
    input  logic               cpu_req_off,
    input  logic [DATA_W-1:0]  cpu_req_wdata,
    output logic               cpu_resp_valid,
    output logic [DATA_W-1:0]  cpu_resp_rdata,
    output logic               cpu_resp_hit,
    output logic [TAG_W-1:0]   arr_tag,
    output logic [SET_W-1:0]   arr_set,
    output logic               arr_off,
    input  logic               arr_hit,
    input  logic               arr_hit_way,
    input  logic [DATA_W-1:0]  arr_rdata,
    input  logic               arr_victim_way,
    input  logic               arr_victim_valid,
    input  logic [TAG_W-1:0]   arr_victim_tag,
    input  logic [BLOCK_W-1:0] arr_victim_block,
    output logic               arr_wr_en,
    output logic [DATA_W-1:0]  arr_wdata,
    output logic               arr_fill_en,
    output logic               arr_fill_way,
    output logic [BLOCK_W-1:0] arr_fill_block,
    output logic               arr_touch_en,
    output logic               arr_touch_way,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_we,
    output logic [TAG_W-1:0]   mem_req_tag,
    output logic [SET_W-1:0]   mem_req_set,
    output logic [BLOCK_W-1:0] mem_req_block,
    input  logic               mem_resp_valid,
    input  logic [BLOCK_W-1:0] mem_resp_block
);

    state_t                    r_state;
    logic                      r_req_ready;
    logic                      r_resp_valid;
    logic [DATA_W-1:0]         r_resp_rdata;
    logic                      r_resp_hit;
    logic [TAG_W-1:0]          r_arr_tag;
    logic [SET_W-1:0]          r_arr_set;
    logic                      r_arr_off;
    logic                      r_we;
    logic [DATA_W-1:0]         r_wdata;
    logic                      r_wr_en;
    logic                      r_fill_en;
    logic [BLOCK_W-1:0]        r_fill_block;
    logic                      r_touch_en;
    logic                      r_touch_way;
    logic [$clog2(WAYS)-1:0]   r_victim_way;
    logic                      r_mem_valid;
    logic                      r_mem_we;
    logic [TAG_W-1:0]          r_mem_tag;
    logic [SET_W-1:0]          r_mem_set;
    logic [BLOCK_W-1:0]        r_mem_block;

    logic                      w_accept;
    logic [BLOCK_W-1:0]        w_merged;

    assign w_accept = cpu_req_valid & r_req_ready;
    assign w_merged = merge_byte(mem_resp_block, r_arr_off, r_wdata, r_we);

    // Outputs are registered: each is set on the edge that enters the state
    // in which it must be seen, so strobes below are cleared by default.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_hit   <= 1'b0;
            r_arr_tag    <= '0;
            r_arr_set    <= '0;
            r_arr_off    <= 1'b0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_wr_en      <= 1'b0;
            r_fill_en    <= 1'b0;
            r_fill_block <= '0;
            r_touch_en   <= 1'b0;
            r_touch_way  <= 1'b0;
            r_victim_way <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_tag    <= '0;
            r_mem_set    <= '0;
            r_mem_block  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_wr_en      <= 1'b0;
            r_fill_en    <= 1'b0;
            r_touch_en   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_arr_tag   <= cpu_req_tag;
                        r_arr_set   <= cpu_req_set;
                        r_arr_off   <= cpu_req_off;
                        r_we        <= cpu_req_we;
                        r_wdata     <= cpu_req_wdata;
                        r_req_ready <= 1'b0;
                        r_state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (arr_hit) begin
                        r_touch_en   <= 1'b1;
                        r_touch_way  <= arr_hit_way;
                        r_wr_en      <= r_we;
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b1;
                        r_resp_rdata <= r_we ? r_wdata : arr_rdata;
                        r_state      <= RESP;
                    end else begin
                        r_victim_way <= arr_victim_way;
                        r_mem_valid  <= 1'b1;
                        r_mem_set    <= r_arr_set;
                        r_mem_block  <= arr_victim_block;
                        if (arr_victim_valid) begin
                            r_mem_we  <= 1'b1;
                            r_mem_tag <= arr_victim_tag;
                            r_state   <= WB;
                        end else begin
                            r_mem_we  <= 1'b0;
                            r_mem_tag <= r_arr_tag;
                            r_state   <= RD;
                        end
                    end
                end
                WB: begin
                    if (mem_req_ready) begin
                        r_mem_we  <= 1'b0;
                        r_mem_tag <= r_arr_tag;
                        r_state   <= RD;
                    end
                end
                RD: begin
                    if (mem_req_ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        r_fill_en    <= 1'b1;
                        r_touch_en   <= 1'b1;
                        r_touch_way  <= r_victim_way;
                        r_fill_block <= w_merged;
                        r_resp_rdata <= pick_byte(w_merged, r_arr_off);
                        r_resp_hit   <= 1'b0;
                        r_state      <= FILL;
                    end
                end
                FILL: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign cpu_req_ready  = r_req_ready;
    assign cpu_resp_valid = r_resp_valid;
    assign cpu_resp_rdata = r_resp_rdata;
    assign cpu_resp_hit   = r_resp_hit;
    assign arr_tag        = r_arr_tag;
    assign arr_set        = r_arr_set;
    assign arr_off        = r_arr_off;
    assign arr_wr_en      = r_wr_en;
    assign arr_wdata      = r_wdata;
    assign arr_fill_en    = r_fill_en;
    assign arr_fill_way   = r_victim_way;
    assign arr_fill_block = r_fill_block;
    assign arr_touch_en   = r_touch_en;
    assign arr_touch_way  = r_touch_way;
    assign mem_req_valid  = r_mem_valid;
    assign mem_req_we     = r_mem_we;
    assign mem_req_tag    = r_mem_tag;
    assign mem_req_set    = r_mem_set;
    assign mem_req_block  = r_mem_block;

`ifdef CACHE_CTRL_PERF_EN
    logic w_hit_resp;
    logic w_miss_resp;
    logic w_wb_hs;

    assign w_hit_resp  = r_resp_valid & r_resp_hit;
    assign w_miss_resp = r_resp_valid & ~r_resp_hit;
    assign w_wb_hs     = (r_state == WB) & r_mem_valid & mem_req_ready;

    cache_perf_cnt u_perf (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_inc_hit  (w_hit_resp),
        .i_inc_miss (w_miss_resp),
        .i_inc_wb   (w_wb_hs),
        .o_hits     (perf_hits),
        .o_misses   (perf_misses),
        .o_wbacks   (perf_wbacks)
    );
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Scoreboard bench for cache_ctrl_fsm with behavioural 2-way array and memory.
module tb_cache_ctrl_fsm;
    import cache_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               cpu_req_valid, cpu_req_ready, cpu_req_we, cpu_req_off;
    logic [2:0]         cpu_req_tag, cpu_req_set;
    logic [7:0]         cpu_req_wdata, cpu_resp_rdata;
    logic               cpu_resp_valid, cpu_resp_hit;
    logic [2:0]         arr_tag, arr_set, arr_victim_tag;
    logic               arr_off, arr_hit, arr_hit_way, arr_victim_way, arr_victim_valid;
    logic [7:0]         arr_rdata, arr_wdata;
    logic [15:0]        arr_victim_block, arr_fill_block;
    logic               arr_wr_en, arr_fill_en, arr_fill_way, arr_touch_en, arr_touch_way;
    logic               mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
    logic [2:0]         mem_req_tag, mem_req_set;
    logic [15:0]        mem_req_block, mem_resp_block;
`ifdef CACHE_CTRL_PERF_EN
    logic [15:0]        perf_hits, perf_misses, perf_wbacks;
`endif

    always #5 clk = ~clk;

    cache_ctrl_fsm u_dut (
        .clk              (clk),
        .rst              (rst),
`ifdef CACHE_CTRL_PERF_EN
        .perf_hits        (perf_hits),
        .perf_misses      (perf_misses),
        .perf_wbacks      (perf_wbacks),
`endif
        .cpu_req_valid    (cpu_req_valid),
        .cpu_req_ready    (cpu_req_ready),
        .cpu_req_we       (cpu_req_we),
        .cpu_req_tag      (cpu_req_tag),
        .cpu_req_set      (cpu_req_set),
        .cpu_req_off      (cpu_req_off),
        .cpu_req_wdata    (cpu_req_wdata),
        .cpu_resp_valid   (cpu_resp_valid),
        .cpu_resp_rdata   (cpu_resp_rdata),
        .cpu_resp_hit     (cpu_resp_hit),
        .arr_tag          (arr_tag),
        .arr_set          (arr_set),
        .arr_off          (arr_off),
        .arr_hit          (arr_hit),
        .arr_hit_way      (arr_hit_way),
        .arr_rdata        (arr_rdata),
        .arr_victim_way   (arr_victim_way),
        .arr_victim_valid (arr_victim_valid),
        .arr_victim_tag   (arr_victim_tag),
        .arr_victim_block (arr_victim_block),
        .arr_wr_en        (arr_wr_en),
        .arr_wdata        (arr_wdata),
        .arr_fill_en      (arr_fill_en),
        .arr_fill_way     (arr_fill_way),
        .arr_fill_block   (arr_fill_block),
        .arr_touch_en     (arr_touch_en),
        .arr_touch_way    (arr_touch_way),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_we       (mem_req_we),
        .mem_req_tag      (mem_req_tag),
        .mem_req_set      (mem_req_set),
        .mem_req_block    (mem_req_block),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_block   (mem_resp_block)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural array: way x set.
    logic        m_valid [2][8];
    logic [2:0]  m_tag   [2][8];
    logic [15:0] m_block [2][8];
    logic        m_lru   [8];

    always_comb begin
        arr_hit     = 1'b0;
        arr_hit_way = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (m_valid[w][arr_set] && (m_tag[w][arr_set] == arr_tag)) begin
                arr_hit     = 1'b1;
                arr_hit_way = 1'(w);
            end
        end
        arr_rdata        = arr_off ? m_block[arr_hit_way][arr_set][15:8]
                                   : m_block[arr_hit_way][arr_set][7:0];
        arr_victim_way   = m_lru[arr_set];
        arr_victim_valid = m_valid[arr_victim_way][arr_set];
        arr_victim_tag   = m_tag[arr_victim_way][arr_set];
        arr_victim_block = m_block[arr_victim_way][arr_set];
    end

    typedef struct packed {
        logic [7:0] rdata;
        logic       hit;
    } resp_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  tag;
        logic [2:0]  set;
        logic [15:0] block;
    } mreq_t;

    resp_t       exp_q[$];
    mreq_t       mem_log[$];
    int unsigned cyc = 0, acc_cyc = 0, last_lat = 0;
    int unsigned resp_cnt = 0, fill_cnt = 0;
    logic [15:0] last_fill_block = '0;
    logic        last_fill_way = 1'b0, last_touch_way = 1'b0;

    int unsigned mem_lat = 3, stall = 0, cd = 0;
    logic [15:0] refill = '0;
    logic [2:0]  exp_wb_tag = '0;
    logic [15:0] exp_wb_block = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Response scoreboard and array side-effects, sampled mid-cycle.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cpu_resp_valid) begin
                    resp_cnt++;
                    last_lat = cyc - acc_cyc;
                    if (exp_q.size() == 0) begin
                        check_eq("resp_spurious", 32'(cpu_resp_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("resp_rdata", 32'(cpu_resp_rdata), 32'(e.rdata));
                        check_eq("resp_hit", 32'(cpu_resp_hit), 32'(e.hit));
                    end
                end
                if (arr_wr_en) begin
                    if (arr_off) m_block[arr_hit_way][arr_set][15:8] = arr_wdata;
                    else         m_block[arr_hit_way][arr_set][7:0]  = arr_wdata;
                end
                if (arr_fill_en) begin
                    fill_cnt++;
                    last_fill_block = arr_fill_block;
                    last_fill_way   = arr_fill_way;
                    m_valid[arr_fill_way][arr_set] = 1'b1;
                    m_tag[arr_fill_way][arr_set]   = arr_tag;
                    m_block[arr_fill_way][arr_set] = arr_fill_block;
                end
                if (arr_touch_en) begin
                    last_touch_way = arr_touch_way;
                    m_lru[arr_set] = ~arr_touch_way;
                end
            end
        end
    end

    // Memory: optional stall on the first request, fixed read latency.
    initial begin
        mreq_t cap;
        cap = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_block = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (mem_req_ready) begin
                mem_log.push_back(cap);
                if (!cap.we) cd = mem_lat;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_block = refill;
                end
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid && !rst) begin
                if (stall > 0) begin
                    stall--;
                    check_eq("wb_hold_we", 32'(mem_req_we), 32'd1);
                    check_eq("wb_hold_tag", 32'(mem_req_tag), 32'(exp_wb_tag));
                    check_eq("wb_hold_set", 32'(mem_req_set), 32'd0);
                    check_eq("wb_hold_block", 32'(mem_req_block), 32'(exp_wb_block));
                    check_eq("wb_hold_cpu_ready", 32'(cpu_req_ready), 32'd0);
                end else begin
                    mem_req_ready = 1'b1;
                    cap = '{we: mem_req_we, tag: mem_req_tag, set: mem_req_set, block: mem_req_block};
                end
            end
        end
    end

    task automatic wait_resp(input int unsigned start);
        int unsigned n = 0;
        while (resp_cnt == start && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("resp_arrived", resp_cnt - start, 32'd1);
    endtask

    task automatic issue(input logic we, input logic [2:0] tag, input logic [2:0] set,
                         input logic off, input logic [7:0] wd,
                         input logic [7:0] er, input logic eh, input logic wt);
        int unsigned n = 0;
        int unsigned start;
        resp_t e;
        @(negedge clk);
        while (!cpu_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        start   = resp_cnt;
        e.rdata = er;
        e.hit   = eh;
        exp_q.push_back(e);
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_tag   = tag;
        cpu_req_set   = set;
        cpu_req_off   = off;
        cpu_req_wdata = wd;
        acc_cyc       = cyc;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_tag   = ~tag;
        cpu_req_set   = ~set;
        cpu_req_off   = ~off;
        cpu_req_wdata = ~wd;
        if (wt) wait_resp(start);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int unsigned nlog, nfill, nresp, n;
        mreq_t m;
        rst = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_we = 1'b0;
        cpu_req_tag = '0;
        cpu_req_set = '0;
        cpu_req_off = 1'b0;
        cpu_req_wdata = '0;
        for (int unsigned s = 0; s < 8; s++) begin
            m_lru[s] = 1'b0;
            for (int unsigned w = 0; w < 2; w++) begin
                m_valid[w][s] = 1'b0;
                m_tag[w][s]   = '0;
                m_block[w][s] = '0;
            end
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_req_ready", 32'(cpu_req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        check_eq("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        check_eq("rst_fill_en", 32'(arr_fill_en), 32'd0);
        check_eq("rst_touch_en", 32'(arr_touch_en), 32'd0);
        check_eq("rst_wr_en", 32'(arr_wr_en), 32'd0);

        // Read hit in set 2 way 1.
        m_valid[1][2] = 1'b1;
        m_tag[1][2]   = 3'd5;
        m_block[1][2] = 16'h3C5A;
        nlog = mem_log.size();
        issue(1'b0, 3'd5, 3'd2, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b1);
        check_eq("hit_latency", last_lat, 32'd2);
        check_eq("hit_no_mem", mem_log.size() - nlog, 32'd0);
        check_eq("hit_touch_way", 32'(last_touch_way), 32'd1);

        // Read miss, empty set 0.
        mem_lat = 3;
        refill  = 16'h1234;
        nlog    = mem_log.size();
        issue(1'b0, 3'd3, 3'd0, 1'b0, 8'h00, 8'h34, 1'b0, 1'b1);
        check_eq("rmiss_latency", last_lat, 32'd7);
        check_eq("rmiss_mem_reqs", mem_log.size() - nlog, 32'd1);
        m = mem_log[nlog];
        check_eq("rmiss_req", 32'({m.we, m.tag, m.set}), 32'({1'b0, 3'd3, 3'd0}));
        check_eq("rmiss_fill_block", 32'(last_fill_block), 32'h1234);
        check_eq("rmiss_fill_way", 32'(last_fill_way), 32'd0);

        // Write miss with valid victim and a stalled writeback.
        m_valid[1][0] = 1'b1;
        m_tag[1][0]   = 3'd2;
        m_block[1][0] = 16'hABCD;
        m_lru[0]      = 1'b1;
        exp_wb_tag    = 3'd2;
        exp_wb_block  = 16'hABCD;
        stall         = 3;
        mem_lat       = 2;
        refill        = 16'h5566;
        nlog          = mem_log.size();
        issue(1'b1, 3'd6, 3'd0, 1'b1, 8'hEE, 8'hEE, 1'b0, 1'b1);
        check_eq("wmiss_stall_done", stall, 32'd0);
        check_eq("wmiss_mem_reqs", mem_log.size() - nlog, 32'd2);
        m = mem_log[nlog];
        check_eq("wmiss_wb_req", 32'({m.we, m.tag, m.set}), 32'({1'b1, 3'd2, 3'd0}));
        check_eq("wmiss_wb_block", 32'(m.block), 32'hABCD);
        m = mem_log[nlog + 1];
        check_eq("wmiss_rd_req", 32'({m.we, m.tag, m.set}), 32'({1'b0, 3'd6, 3'd0}));
        check_eq("wmiss_fill_block", 32'(last_fill_block), 32'hEE66);
        check_eq("wmiss_fill_way", 32'(last_fill_way), 32'd1);

        // Write hit then readback of both bytes and the other way.
        nlog = mem_log.size();
        issue(1'b1, 3'd6, 3'd0, 1'b0, 8'h77, 8'h77, 1'b1, 1'b1);
        check_eq("whit_latency", last_lat, 32'd2);
        issue(1'b0, 3'd6, 3'd0, 1'b0, 8'h00, 8'h77, 1'b1, 1'b1);
        issue(1'b0, 3'd6, 3'd0, 1'b1, 8'h00, 8'hEE, 1'b1, 1'b1);
        issue(1'b0, 3'd3, 3'd0, 1'b0, 8'h00, 8'h34, 1'b1, 1'b1);
        check_eq("hits_no_mem", mem_log.size() - nlog, 32'd0);

        // Reset while waiting for refill data: transaction is dropped.
        mem_lat = 6;
        refill  = 16'hFFFF;
        nlog    = mem_log.size();
        issue(1'b0, 3'd1, 3'd3, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
        n = 0;
        while (mem_log.size() == nlog && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rstwait_rd_issued", mem_log.size() - nlog, 32'd1);
        nfill = fill_cnt;
        nresp = resp_cnt;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_eq("inrst_mem_valid", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("rstwait_no_fill", fill_cnt - nfill, 32'd0);
        check_eq("rstwait_no_resp", resp_cnt - nresp, 32'd0);
        check_eq("rstwait_req_ready", 32'(cpu_req_ready), 32'd1);
        check_eq("rstwait_mem_idle", 32'(mem_req_valid), 32'd0);

        // Three hits, then a clean miss and a miss with writeback.
        issue(1'b0, 3'd5, 3'd2, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b1);
        issue(1'b0, 3'd5, 3'd2, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b1);
        issue(1'b0, 3'd3, 3'd0, 1'b0, 8'h00, 8'h34, 1'b1, 1'b1);
        mem_lat = 1;
        refill  = 16'h9A0B;
        issue(1'b0, 3'd1, 3'd4, 1'b1, 8'h00, 8'h9A, 1'b0, 1'b1);
        m_valid[0][5] = 1'b1;
        m_tag[0][5]   = 3'd0;
        m_block[0][5] = 16'h2222;
        m_valid[1][5] = 1'b1;
        m_tag[1][5]   = 3'd7;
        m_block[1][5] = 16'h1111;
        m_lru[5]      = 1'b1;
        refill        = 16'hC3D4;
        nlog          = mem_log.size();
        issue(1'b0, 3'd4, 3'd5, 1'b0, 8'h00, 8'hD4, 1'b0, 1'b1);
        check_eq("miss2_mem_reqs", mem_log.size() - nlog, 32'd2);
        m = mem_log[nlog];
        check_eq("miss2_wb_req", 32'({m.we, m.tag, m.set, m.block}), 32'({1'b1, 3'd7, 3'd5, 16'h1111}));
        check_eq("miss2_fill", 32'({last_fill_way, last_fill_block}), 32'({1'b1, 16'hC3D4}));
`ifdef CACHE_CTRL_PERF_EN
        check_eq("perf_hits", 32'(perf_hits), 32'd3);
        check_eq("perf_misses", 32'(perf_misses), 32'd2);
        check_eq("perf_wbacks", 32'(perf_wbacks), 32'd1);
`endif
        check_eq("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
